// File: rtl/inv_path_bist_ctrl.sv
// Purpose: BIST sequencer for the inverter-pair path; drives LFSR bits, waits, samples, compares.
// Latency: SETTLE+2 cycles per vector; done pulses 1+V*(SETTLE+2) cycles after the start edge.
// Backpressure: none; start is ignored unless idle, abort ends a run early without a done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, abort    begin a run (idle only) / terminate a run (any non-idle state)
//   num_vectors     vectors per run, latched on start
//   chain_in        bit returned from the path under test
//   stim_out        stimulus bit into the path under test
//   busy            high while vectors are being driven/settled/sampled
//   done            one-cycle pulse at run completion
//   pass            result of the last completed run, held until the next start
//   err_count       mismatches in the current/last run
//   first_fail      index of the first mismatching vector, 8'hFF if none
module inv_path_bist_ctrl #(
  parameter int         SETTLE = 2,
  parameter int         INVERT = 0,
  parameter logic [7:0] SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] num_vectors,
  input  logic       chain_in,
  output logic       stim_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_fail
);

  // Settle down-counter is loaded with SETTLE-1 and the SETTLE state exits at zero.
  localparam int             CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  SETTLE_LOAD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
  localparam logic           INV_BIT     = (INVERT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    lfsr;
  logic [7:0]    vec_idx;
  logic [7:0]    vec_count;
  logic          expected;
  logic [CW-1:0] settle_cnt;

  logic lfsr_fb;
  logic last_vec;
  logic mismatch;
  logic abort_run;

  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  // Compare in 9 bits so vec_idx+1 can equal a latched count of 255 without wrapping.
  assign last_vec  = (({1'b0, vec_idx} + 9'd1) == {1'b0, vec_count});
  assign mismatch  = (chain_in != expected);
  assign abort_run = abort && (state != S_IDLE);
  assign busy      = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_SAMPLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_vectors == 8'd0) ? S_DONE : S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        state_nxt = last_vec ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort_run) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim_out   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      first_fail <= 8'hFF;
      lfsr       <= SEED;
      vec_idx    <= 8'd0;
      vec_count  <= 8'd0;
      expected   <= 1'b0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort_run) begin
        // Partial err_count/first_fail are kept for inspection; the sample in flight is dropped.
        pass <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              vec_count  <= num_vectors;
              lfsr       <= SEED;
              err_count  <= 8'd0;
              pass       <= 1'b0;
              vec_idx    <= 8'd0;
              first_fail <= 8'hFF;
            end
          end
          S_DRIVE: begin
            stim_out   <= lfsr[0];
            expected   <= lfsr[0] ^ INV_BIT;
            settle_cnt <= SETTLE_LOAD;
          end
          S_SETTLE: begin
            settle_cnt <= settle_cnt - CW'(1);
          end
          S_SAMPLE: begin
            if (mismatch) begin
              err_count <= err_count + 8'd1;
              if (first_fail == 8'hFF) begin
                first_fail <= vec_idx;
              end
            end
            lfsr    <= {lfsr[6:0], lfsr_fb};
            vec_idx <= vec_idx + 8'd1;
          end
          S_DONE: begin
            // err_count already includes the last sample here.
            done <= 1'b1;
            pass <= (err_count == 8'd0);
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inv_path_bist_ctrl.sv
module tb_inv_path_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_vectors = 8'd0;
  int         mode = 0;       // 0 loop, 1 inverted loop, 2 tied 0, 3 tied 1, 4 random
  logic       rnd_bit = 1'b0;

  logic       chain0, stim0, busy0, done0, pass0;
  logic [7:0] err0, ff0;
  logic       chain1, stim1, busy1, done1, pass1;
  logic [7:0] err1, ff1;

  function automatic logic chain_fn(input int m, input logic s, input logic r);
    case (m)
      0:       return s;
      1:       return ~s;
      2:       return 1'b0;
      3:       return 1'b1;
      default: return r;
    endcase
  endfunction

  assign chain0 = chain_fn(mode, stim0, rnd_bit);
  assign chain1 = chain_fn(mode, stim1, rnd_bit);

  inv_path_bist_ctrl #(.SETTLE(2), .INVERT(0), .SEED(8'hA5)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vectors(num_vectors),
    .chain_in(chain0), .stim_out(stim0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0)
  );

  inv_path_bist_ctrl #(.SETTLE(0), .INVERT(1), .SEED(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vectors(num_vectors),
    .chain_in(chain1), .stim_out(stim1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run started at edge T is a timeline: vector k occupies cycles T+k*P .. T+k*P+P-1
  // (P = settle+2); its bit appears on stim the cycle after T+k*P, chain is judged in
  // the last cycle of the slot, and done shows up in cycle T+1+V*P.
  int   per [2] = '{4, 2};
  logic inv [2] = '{1'b0, 1'b1};

  bit         m_active [2];
  int         m_T [2];
  int         m_V [2];
  logic       m_stim [2];
  logic       m_done [2];
  logic       m_pass [2];
  logic [7:0] m_err [2];
  logic [7:0] m_ff [2];
  bit         m_bits [2][256];

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic m_busy(input int d);
    return m_active[d] && ((cyc - m_T[d]) < m_V[d] * per[d]);
  endfunction

  always @(posedge clk) begin
    logic       ch;
    logic [7:0] l;
    int         r, k, ph;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      ch = chain_fn(mode, m_stim[d], rnd_bit);
      if (rst) begin
        m_active[d] = 1'b0;
        m_stim[d]   = 1'b0;
        m_done[d]   = 1'b0;
        m_pass[d]   = 1'b0;
        m_err[d]    = 8'd0;
        m_ff[d]     = 8'hFF;
      end else if (m_active[d]) begin
        r = cyc - 1 - m_T[d];
        m_done[d] = 1'b0;
        if (abort) begin
          m_active[d] = 1'b0;
          m_pass[d]   = 1'b0;
        end else if (r < m_V[d] * per[d]) begin
          k  = r / per[d];
          ph = r % per[d];
          if (ph == 0) m_stim[d] = m_bits[d][k];
          if (ph == per[d] - 1 && ch != (m_bits[d][k] ^ inv[d])) begin
            m_err[d] = m_err[d] + 8'd1;
            if (m_ff[d] == 8'hFF) m_ff[d] = k[7:0];
          end
        end else begin
          m_done[d]   = 1'b1;
          m_pass[d]   = (m_err[d] == 8'd0);
          m_active[d] = 1'b0;
        end
      end else begin
        m_done[d] = 1'b0;
        if (start) begin
          m_active[d] = 1'b1;
          m_T[d]      = cyc;
          m_V[d]      = int'(num_vectors);
          m_err[d]    = 8'd0;
          m_pass[d]   = 1'b0;
          m_ff[d]     = 8'hFF;
          l = 8'hA5;
          for (int j = 0; j < 256; j++) begin
            m_bits[d][j] = l[0];
            l = lfsr_step(l);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    rnd_bit = 1'($urandom_range(0, 1));
    chk("d0_busy", 32'(busy0), 32'(m_busy(0)));
    chk("d0_done", 32'(done0), 32'(m_done[0]));
    chk("d0_pass", 32'(pass0), 32'(m_pass[0]));
    chk("d0_stim", 32'(stim0), 32'(m_stim[0]));
    chk("d0_err",  32'(err0),  32'(m_err[0]));
    chk("d0_ff",   32'(ff0),   32'(m_ff[0]));
    chk("d1_busy", 32'(busy1), 32'(m_busy(1)));
    chk("d1_done", 32'(done1), 32'(m_done[1]));
    chk("d1_pass", 32'(pass1), 32'(m_pass[1]));
    chk("d1_stim", 32'(stim1), 32'(m_stim[1]));
    chk("d1_err",  32'(err1),  32'(m_err[1]));
    chk("d1_ff",   32'(ff1),   32'(m_ff[1]));
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input int nv, input int m, output int t);
    @(negedge clk);
    mode        = m;
    num_vectors = nv[7:0];
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_done0(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done0 === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done0_timeout", 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!m_active[0] && !m_active[1] && busy0 === 1'b0 && busy1 === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, at, seen, nv, m, len;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_stim", 32'(stim0), 32'd0);
    chk("rst_err",  32'(err0),  32'd0);
    chk("rst_ff",   32'(ff0),   32'hFF);

    // Loopback, 16 vectors: done at T+65, clean pass.
    do_start(16, 0, t);
    wait_done0(200, at);
    chk("t1_done_cycle", 32'(at - t), 32'd65);
    chk("t1_pass", 32'(pass0), 32'd1);
    chk("t1_err",  32'(err0),  32'd0);
    chk("t1_ff",   32'(ff0),   32'hFF);

    // Tied 0, 3 vectors: expected bits 1,0,1.
    do_start(3, 2, t);
    chk("lfsr_bit0", 32'(m_bits[0][0]), 32'd1);
    chk("lfsr_bit1", 32'(m_bits[0][1]), 32'd0);
    chk("lfsr_bit2", 32'(m_bits[0][2]), 32'd1);
    wait_done0(50, at);
    chk("t2_err",  32'(err0),  32'd2);
    chk("t2_ff",   32'(ff0),   32'd0);
    chk("t2_pass", 32'(pass0), 32'd0);
    chk("t2_inv_err", 32'(err1), 32'd1);
    chk("t2_inv_ff",  32'(ff1),  32'd1);

    // Tied 1, 3 vectors.
    do_start(3, 3, t);
    wait_done0(50, at);
    chk("t3_err",  32'(err0),  32'd1);
    chk("t3_ff",   32'(ff0),   32'd1);
    chk("t3_pass", 32'(pass0), 32'd0);
    chk("t3_inv_err", 32'(err1), 32'd2);
    chk("t3_inv_ff",  32'(ff1),  32'd0);

    // Inverted loop, 255 vectors: INVERT=1 passes, INVERT=0 fails every vector.
    do_start(255, 1, t);
    wait_done0(1100, at);
    chk("t4_done_cycle", 32'(at - t), 32'd1021);
    chk("t4_err",  32'(err0),  32'd255);
    chk("t4_ff",   32'(ff0),   32'd0);
    chk("t4_pass", 32'(pass0), 32'd0);
    chk("t4_inv_err",  32'(err1),  32'd0);
    chk("t4_inv_ff",   32'(ff1),   32'hFF);
    chk("t4_inv_pass", 32'(pass1), 32'd1);

    // Zero vectors, with start held through the DONE cycle.
    @(negedge clk);
    mode = 0; num_vectors = 8'd0; start = 1'b1;
    @(negedge clk);
    chk("t5_busy_a", 32'(busy0), 32'd0);
    chk("t5_done_a", 32'(done0), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("t5_done_b", 32'(done0), 32'd1);
    chk("t5_pass",   32'(pass0), 32'd1);
    chk("t5_busy_b", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("t5_busy_c", 32'(busy0), 32'd0);
    chk("t5_done_c", 32'(done0), 32'd0);

    // Abort during vector 5.
    do_start(20, 0, t);
    while (cyc < t + 21) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_busy", 32'(busy0), 32'd0);
    chk("t6_pass", 32'(pass0), 32'd0);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done0 === 1'b1 || done1 === 1'b1) seen++;
    end
    chk("t6_no_done", 32'(seen), 32'd0);

    // Reset mid-run, then a clean run from SEED.
    do_start(10, 2, t);
    while (cyc < t + 13) @(negedge clk);
    chk("t7_partial_err", 32'(err0), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_busy", 32'(busy0), 32'd0);
    chk("t7_stim", 32'(stim0), 32'd0);
    chk("t7_err",  32'(err0),  32'd0);
    chk("t7_ff",   32'(ff0),   32'hFF);
    chk("t7_pass", 32'(pass0), 32'd0);
    do_start(5, 0, t);
    wait_done0(50, at);
    chk("t7_rerun_cycle", 32'(at - t), 32'd21);
    chk("t7_rerun_pass",  32'(pass0),  32'd1);

    // Randomized runs with stray starts and aborts.
    for (int it = 0; it < 40; it++) begin
      m  = $urandom_range(0, 4);
      nv = $urandom_range(0, 24);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_start(nv, m, t);
      len = $urandom_range(0, nv * 4 + 4);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        abort = ($urandom_range(0, 31) == 0);
        start = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      wait_idle(300);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
